// File: rtl/dmem_lsu.sv
// dmem_lsu: registered RV32I load/store unit over a word-organised RAM with byte-lane steering.
// Define DMEM_MISALIGN_EN to split misaligned accesses across two words instead of rejecting them.
module dmem_lsu #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err
);
    localparam int IW    = ADDR_W - 2;
    localparam int DEPTH = 1 << IW;

    function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{d[7]}}, d[7:0]};
            3'b001:  res = {{16{d[15]}}, d[15:0]};
            3'b010:  res = d;
            3'b100:  res = {24'h00_0000, d[7:0]};
            3'b101:  res = {16'h0000, d[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0]   r_mem [DEPTH];
    logic          r_ready;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_accept;
    logic          w_legal;
    logic          w_mis;
    logic [3:0]    w_be_base;
    logic [3:0]    w_be_lo;
    logic [31:0]   w_wd_lo;
    logic [31:0]   w_rd_sh;
    logic          w_we_en;
    logic [IW-1:0] w_we_idx;
    logic [3:0]    w_we_be;
    logic [31:0]   w_we_data;
    logic          w_valid_nx;
    logic          w_err_nx;
    logic          w_ready_nx;
    logic [31:0]   w_rdata_nx;

    assign w_idx        = i_req_addr[ADDR_W-1:2];
    assign w_lane       = i_req_addr[1:0];
    assign w_accept     = i_req_valid & r_ready;
    assign w_rd_sh      = r_mem[w_idx] >> {w_lane, 3'b000};
    assign o_req_ready  = r_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    // Decode legality, access size and misalignment from funct3 and lane.
    always_comb begin
        w_legal   = 1'b0;
        w_be_base = 4'b0000;
        case (i_req_funct3)
            3'b000:         begin w_legal = 1'b1; w_be_base = 4'b0001; end
            3'b001:         begin w_legal = 1'b1; w_be_base = 4'b0011; end
            3'b010:         begin w_legal = 1'b1; w_be_base = 4'b1111; end
            3'b100, 3'b101: w_legal = ~i_req_we;
            default:        w_legal = 1'b0;
        endcase
        w_mis = ((i_req_funct3[1:0] == 2'b01) && w_lane[0]) ||
                ((i_req_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
    end

`ifdef DMEM_MISALIGN_EN
    typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;
    state_t        r_state;
    state_t        w_state_nx;
    logic [31:0]   r_hold;
    logic [31:0]   r_hi_data;
    logic [3:0]    r_hi_be;
    logic [1:0]    r_lane;
    logic [2:0]    r_f3;
    logic          r_we_q;
    logic [IW-1:0] r_idx2;
    logic [7:0]    w_be64;
    logic [63:0]   w_wd64;
    logic [31:0]   w_merge;

    // Lanes spill past byte 3 into the upper half, which belongs to the next word.
    assign w_be64  = {4'b0000, w_be_base} << w_lane;
    assign w_wd64  = {32'h0000_0000, i_req_wdata} << {w_lane, 3'b000};
    assign w_be_lo = w_be64[3:0];
    assign w_wd_lo = w_wd64[31:0];

    // Join the held first-word bytes (lane..3) with the low bytes of the next word.
    always_comb begin
        case (r_lane)
            2'd1:    w_merge = {r_mem[r_idx2][7:0],  r_hold[31:8]};
            2'd2:    w_merge = {r_mem[r_idx2][15:0], r_hold[31:16]};
            2'd3:    w_merge = {r_mem[r_idx2][23:0], r_hold[31:24]};
            default: w_merge = r_hold;
        endcase
    end

    // Capture the context of a misaligned request for the second access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= 32'h0000_0000;
            r_hi_data <= 32'h0000_0000;
            r_hi_be   <= 4'b0000;
            r_lane    <= 2'b00;
            r_f3      <= 3'b000;
            r_we_q    <= 1'b0;
            r_idx2    <= '0;
        end else if (w_accept && w_legal && w_mis) begin
            r_hold    <= r_mem[w_idx];
            r_hi_data <= w_wd64[63:32];
            r_hi_be   <= w_be64[7:4];
            r_lane    <= w_lane;
            r_f3      <= i_req_funct3;
            r_we_q    <= i_req_we;
            r_idx2    <= w_idx + IW'(1);
        end
    end
`else
    assign w_be_lo = w_be_base << w_lane;
    assign w_wd_lo = i_req_wdata << {w_lane, 3'b000};
`endif

    // Next-state, array write port and next response values.
    always_comb begin
        w_we_en    = 1'b0;
        w_we_idx   = w_idx;
        w_we_be    = w_be_lo;
        w_we_data  = w_wd_lo;
        w_valid_nx = 1'b0;
        w_rdata_nx = 32'h0000_0000;
        w_err_nx   = 1'b0;
        w_ready_nx = 1'b1;
`ifdef DMEM_MISALIGN_EN
        w_state_nx = r_state;
        if (r_state == S_SPLIT) begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b1;
            w_we_idx   = r_idx2;
            w_we_be    = r_hi_be;
            w_we_data  = r_hi_data;
            if (r_we_q) begin
                w_we_en = 1'b1;
            end else begin
                w_rdata_nx = f_extend(w_merge, r_f3);
            end
        end else if (w_accept) begin
            if (!w_legal) begin
                w_valid_nx = 1'b1;
                w_err_nx   = 1'b1;
            end else if (w_mis) begin
                w_state_nx = S_SPLIT;
                w_ready_nx = 1'b0;
                w_we_en    = i_req_we;
            end else begin
                w_valid_nx = 1'b1;
                w_we_en    = i_req_we;
                w_rdata_nx = i_req_we ? 32'h0000_0000 : f_extend(w_rd_sh, i_req_funct3);
            end
        end else begin
            w_state_nx = S_IDLE;
        end
`else
        if (w_accept) begin
            w_valid_nx = 1'b1;
            if (!w_legal || w_mis) begin
                w_err_nx = 1'b1;
            end else begin
                w_we_en    = i_req_we;
                w_rdata_nx = i_req_we ? 32'h0000_0000 : f_extend(w_rd_sh, i_req_funct3);
            end
        end else begin
            w_valid_nx = 1'b0;
        end
`endif
    end

    // State and registered response/ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
            r_state      <= S_IDLE;
`endif
        end else begin
            r_ready      <= w_ready_nx;
            r_resp_valid <= w_valid_nx;
            r_resp_rdata <= w_rdata_nx;
            r_resp_err   <= w_err_nx;
`ifdef DMEM_MISALIGN_EN
            r_state      <= w_state_nx;
`endif
        end
    end

    // Byte-enabled array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_we_be[b]) begin
                    r_mem[w_we_idx][8*b +: 8] <= w_we_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data-memory load/store unit. Holds a word-organised RAM of 2^(ADDR_W-2) 32-bit words and serves RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) through a valid/ready request port and a single-cycle response pulse. It handles byte-lane steering, sign/zero extension, misalignment detection and illegal-funct3 detection. It sits between the core's MEM stage and the storage array, replacing the combinational data memory with a registered, handshaked interface.

## Interface
- ADDR_W, 11: byte-address width; depth = 2^(ADDR_W-2) words, ADDR_W ≥ 3.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  access rejected, memory unchanged.

## Operation
- Handshake: transfer when req_valid & req_ready. Inputs are sampled only on transfer. No resp_ready; the core always accepts.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 → resp_err=1, no array access.
- Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
- Stores: byte enables SB 0001<<lane, SH 0011<<lane, SW 1111. Data is shifted onto the selected lanes; unselected bytes are unchanged.
- Loads: select the byte or half at lane. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned: LH/LHU/SH with lane[0]=1, or LW/SW with lane≠0. Handling depends on DMEM_MISALIGN_EN (see Configuration).
- FSM: IDLE and SPLIT.
  - IDLE: req_ready=1. Aligned or error requests stay in IDLE.
  - IDLE → SPLIT: a misaligned request is transferred with the macro defined.
  - SPLIT: req_ready=0. Performs the second word access, then returns to IDLE.
- Split access:
  - First word holds bytes lane..3. Second word (index+1, wrapping modulo depth) holds the remaining bytes from lane 0 upward.
  - Load: first-word bytes are captured in a holding register and merged with the second word, then extended.
  - Store: low part is written in the accept cycle, high part in the SPLIT cycle.

## Timing
- Reset values: req_ready=0 while rst_n=0, 1 from the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE. Array contents are not reset.
- Aligned, illegal or misaligned-error requests: accepted at edge T; the write or read happens at T; resp_valid=1 during cycle T+1 only. Back-to-back accepts are allowed every cycle, so throughput is 1 request per cycle.
- Split request: accepted at T; second access at T+1; resp_valid during T+2. req_ready=0 during T+1.
- Read-after-write: a load accepted the cycle after a store to the same word returns the newly written data (array write at T precedes read at T+1).
- Reset asserted in SPLIT: the operation is abandoned and no response is given. For a store, the first-half write stands and the second half is dropped.
- req_valid is ignored while req_ready=0 and is not buffered.

## Configuration
- DMEM_MISALIGN_EN defined: misaligned accesses use the SPLIT sequence with resp_err=0.
- DMEM_MISALIGN_EN undefined:
  - Misaligned accesses return resp_err=1, resp_rdata=0 at T+1, with no write.
  - The SPLIT state, holding register and second-access logic are absent.
  - req_ready is constant 1 after reset.

## Test plan
- SW 0x8000_00FF @0x10, then LB @0x10 → 0xFFFF_FFFF. LBU @0x13 → 0x0000_0080. LW @0x10 → 0x8000_00FF, each resp at accept+1.
- SH 0xBEEF @0x22 over a prior SW 0x1122_3344 @0x20 → LW @0x20 = 0xBEEF_3344. LHU @0x22 = 0x0000_BEEF. LH @0x22 = 0xFFFF_BEEF.
- Illegal funct3 3'b011 load and 3'b100 store → resp_err=1, resp_rdata=0. A following LW shows memory unchanged.
- Macro on: SW 0xAABB_CCDD @0x7FE (ADDR_W=11, top word) → words 0x1FF and 0x000 updated with wrap. LW @0x7FE returns 0xAABB_CCDD at accept+2; req_ready low for one cycle. Macro off: same request → resp_err=1 at accept+1.
- Back-to-back: 8 aligned LW on consecutive cycles → 8 consecutive resp_valid pulses with correct data.
- rst_n pulsed low during SPLIT of a misaligned SW → no resp_valid. The first-half bytes are written and the second-half bytes keep their old values. req_ready returns 1 after release.
